nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 136 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two W = 4*NIBBLES bit operands one nibble per clock through an
//   external 4-bit ripple-carry adder. The block drives the adder inputs
//   from registers and registers the adder outputs, building the wide sum
//   from the bottom nibble upward.
//
// Ports
//   clk, resetn           clock (rising edge), async active-low reset
//   in_valid/in_ready     operand handshake; op_a, op_b, op_cin captured on accept
//   add_a/add_b/add_cin   to external adder (zero unless running)
//   add_s/add_cout        combinational response from external adder
//   out_valid/out_ready   result handshake; result, cout, overflow held in DONE
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   op_cin,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   overflow
);

    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic [W-1:0]   r_a_sh;
    logic [W-1:0]   r_b_sh;
    logic [W-1:0]   r_result;
    logic           r_carry;
    logic           r_cout;
    logic           r_ovf;
    logic [3:0]     r_idx;

    logic           w_accept;
    logic           w_run;
    logic           w_last;
    logic [W-1:0]   w_result_nx;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_run    = (r_state == RUN);
    assign w_last   = (r_idx == 4'(NIBBLES - 1));

    // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
    assign w_result_nx = (W'(add_s) << (W - 4)) | (r_result >> 4);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state and handshake/adder outputs
    always_comb begin
        w_state_nx = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_a      = 4'd0;
        add_b      = 4'd0;
        add_cin    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nx = RUN;
            end
            RUN: begin
                add_a   = r_a_sh[3:0];
                add_b   = r_b_sh[3:0];
                add_cin = r_carry;
                if (w_last) w_state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // in_valid is deliberately not looked at here: accept only from IDLE.
                if (out_ready) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_idx    <= 4'd0;
        end else if (w_accept) begin
            r_a_sh   <= op_a;
            r_b_sh   <= op_b;
            r_result <= '0;
            r_carry  <= op_cin;
            r_idx    <= 4'd0;
        end else if (w_run) begin
            r_result <= w_result_nx;
            r_carry  <= add_cout;
            r_a_sh   <= r_a_sh >> 4;
            r_b_sh   <= r_b_sh >> 4;
            r_idx    <= r_idx + 4'd1;
            if (w_last) begin
                r_cout <= add_cout;
                // Top nibble carries the operand sign bits in bit 3.
                r_ovf  <= (r_a_sh[3] == r_b_sh[3]) && (add_s[3] != r_a_sh[3]);
            end
        end
    end

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: three instances (NIBBLES = 1, 4, 8), each
// with its own behavioural 4-bit adder. A select variable routes the shared
// stimulus to one instance at a time; expected results go into a scoreboard
// queue on accept and are popped when the selected instance shows out_valid.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        resetn;
    int          sel;            // 0: NIBBLES=1, 1: NIBBLES=4, 2: NIBBLES=8
    logic        in_valid, out_ready, op_cin;
    logic [31:0] op_a, op_b;

    always #5 clk = ~clk;

    // NIBBLES = 1
    logic        ir1, ov1, ac1, aco1, co1, of1;
    logic [3:0]  aa1, ab1, as1, res1;
    // NIBBLES = 4
    logic        ir4, ov4, ac4, aco4, co4, of4;
    logic [3:0]  aa4, ab4, as4;
    logic [15:0] res4;
    // NIBBLES = 8
    logic        ir8, ov8, ac8, aco8, co8, of8;
    logic [3:0]  aa8, ab8, as8;
    logic [31:0] res8;

    assign {aco1, as1} = 5'(aa1) + 5'(ab1) + 5'(ac1);
    assign {aco4, as4} = 5'(aa4) + 5'(ab4) + 5'(ac4);
    assign {aco8, as8} = 5'(aa8) + 5'(ab8) + 5'(ac8);

    nibble_serial_adder #(.NIBBLES(1)) u_n1 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid && sel == 0), .in_ready(ir1),
        .op_a(op_a[3:0]), .op_b(op_b[3:0]), .op_cin(op_cin),
        .add_a(aa1), .add_b(ab1), .add_cin(ac1), .add_s(as1), .add_cout(aco1),
        .out_valid(ov1), .out_ready(out_ready && sel == 0),
        .result(res1), .cout(co1), .overflow(of1));

    nibble_serial_adder #(.NIBBLES(4)) u_n4 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid && sel == 1), .in_ready(ir4),
        .op_a(op_a[15:0]), .op_b(op_b[15:0]), .op_cin(op_cin),
        .add_a(aa4), .add_b(ab4), .add_cin(ac4), .add_s(as4), .add_cout(aco4),
        .out_valid(ov4), .out_ready(out_ready && sel == 1),
        .result(res4), .cout(co4), .overflow(of4));

    nibble_serial_adder #(.NIBBLES(8)) u_n8 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid && sel == 2), .in_ready(ir8),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .add_a(aa8), .add_b(ab8), .add_cin(ac8), .add_s(as8), .add_cout(aco8),
        .out_valid(ov8), .out_ready(out_ready && sel == 2),
        .result(res8), .cout(co8), .overflow(of8));

    // View of the selected instance
    logic        m_ir, m_ov, m_ac, m_co, m_of;
    logic [3:0]  m_aa, m_ab;
    logic [31:0] m_res;
    always_comb begin
        m_ir = 1'b0; m_ov = 1'b0; m_ac = 1'b0; m_co = 1'b0; m_of = 1'b0;
        m_aa = 4'd0; m_ab = 4'd0; m_res = 32'd0;
        case (sel)
            0: begin
                m_ir = ir1; m_ov = ov1; m_ac = ac1; m_co = co1; m_of = of1;
                m_aa = aa1; m_ab = ab1; m_res = 32'(res1);
            end
            1: begin
                m_ir = ir4; m_ov = ov4; m_ac = ac4; m_co = co4; m_of = of4;
                m_aa = aa4; m_ab = ab4; m_res = 32'(res4);
            end
            default: begin
                m_ir = ir8; m_ov = ov8; m_ac = ac8; m_co = co8; m_of = of8;
                m_aa = aa8; m_ab = ab8; m_res = res8;
            end
        endcase
    end

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        of;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nib_of_sel(input int s);
        return (s == 0) ? 1 : (s == 1) ? 4 : 8;
    endfunction

    // Reference: plain wide addition, then signed overflow from operand/result signs.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input int n);
        exp_t        e;
        int          w;
        logic [32:0] sum;
        logic [32:0] mask;
        w    = 4 * n;
        mask = (33'd1 << w) - 33'd1;
        sum  = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 33'(cin);
        e.res = sum[31:0] & mask[31:0];
        e.co  = sum[w];
        e.of  = (a[w-1] == b[w-1]) && (e.res[w-1] != a[w-1]);
        return e;
    endfunction

    // Called #1 after an edge. Waits for in_ready, presents operands for one accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin);
        int t = 0;
        while (!m_ir && t < 100) begin @(posedge clk); #1; t++; end
        chk("in_ready_wait", 32'(m_ir), 32'd1);
        in_valid = 1'b1; op_a = a; op_b = b; op_cin = cin;
        sb.push_back(model(a, b, cin, nib_of_sel(sel)));
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom; op_cin = 1'b0;
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!m_ov && t < 100) begin @(posedge clk); #1; t++; end
        chk("out_valid_wait", 32'(m_ov), 32'd1);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_result"},   m_res,       e.res);
        chk({tag, "_cout"},     32'(m_co),   32'(e.co));
        chk({tag, "_overflow"}, 32'(m_of),   32'(e.of));
    endtask

    task automatic handshake(input int stall);
        repeat (stall) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int stall);
        wait_valid();
        pop_cmp(tag);
        handshake(stall);
    endtask

    initial begin
        logic [31:0] va, vb, nib;
        logic        seen;
        exp_t        held;

        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_cin = 1'b0;
        op_a = 32'd0; op_b = 32'd0; sel = 1;
        #22;
        chk("rst_in_ready",  32'(m_ir), 32'd1);
        chk("rst_out_valid", 32'(m_ov), 32'd0);
        chk("rst_result",    m_res,     32'd0);
        chk("rst_cout",      32'(m_co), 32'd0);
        chk("rst_overflow",  32'(m_of), 32'd0);
        chk("rst_add_a",     32'(m_aa), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // 1. Basic add, nibble sequence and latency
        send(32'h1234, 32'h4321, 1'b0);
        va = 32'h1234; vb = 32'h4321;
        for (int k = 0; k < 4; k++) begin
            nib = (va >> (4 * k)) & 32'hF;
            chk($sformatf("basic_add_a%0d", k), 32'(m_aa), nib);
            nib = (vb >> (4 * k)) & 32'hF;
            chk($sformatf("basic_add_b%0d", k), 32'(m_ab), nib);
            chk($sformatf("basic_ov_low%0d", k), 32'(m_ov), 32'd0);
            @(posedge clk); #1;
        end
        chk("basic_latency_ov", 32'(m_ov), 32'd1);
        chk("basic_done_add_a", 32'(m_aa), 32'd0);
        chk("basic_done_cin",   32'(m_ac), 32'd0);
        wait_result("basic", 0);
        chk("basic_back_idle", 32'(m_ir), 32'd1);

        // 2. Carry ripple
        send(32'hFFFF, 32'h0001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ripple_cin%0d", k), 32'(m_ac), (k == 0) ? 32'd0 : 32'd1);
            @(posedge clk); #1;
        end
        wait_result("ripple", 0);

        // 3. Signed overflow
        send(32'h7FFF, 32'h0001, 1'b0);
        wait_result("ovf_pos", 0);
        send(32'h8000, 32'h8000, 1'b0);
        wait_result("ovf_neg", 0);

        // 4. Backpressure, then simultaneous release + new request
        send(32'h1111, 32'h2222, 1'b0);
        wait_valid();
        pop_cmp("bp");
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; op_a = $urandom; op_b = $urandom; op_cin = 1'b1;
            @(posedge clk); #1;
            chk("bp_result_hold", m_res,     32'h3333);
            chk("bp_in_ready",    32'(m_ir), 32'd0);
            chk("bp_out_valid",   32'(m_ov), 32'd1);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        op_a = 32'h0102; op_b = 32'h0304; op_cin = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_idle", 32'(m_ir), 32'd1);
        chk("bp_release_ov",   32'(m_ov), 32'd0);
        sb.push_back(model(32'h0102, 32'h0304, 1'b0, 4));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_accepted", 32'(m_ir), 32'd0);
        wait_result("bp_next", 0);

        // 5. Reset mid-RUN
        send(32'h1234, 32'h4321, 1'b0);
        void'(sb.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(m_ov), 32'd0);
        chk("mid_rst_result",    m_res,     32'd0);
        chk("mid_rst_cout",      32'(m_co), 32'd0);
        chk("mid_rst_overflow",  32'(m_of), 32'd0);
        chk("mid_rst_add_a",     32'(m_aa), 32'd0);
        chk("mid_rst_add_b",     32'(m_ab), 32'd0);
        chk("mid_rst_add_cin",   32'(m_ac), 32'd0);
        chk("mid_rst_in_ready",  32'(m_ir), 32'd1);
        #2 resetn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (m_ov) seen = 1'b1;
        end
        chk("mid_rst_no_valid", 32'(seen), 32'd0);
        chk("mid_rst_ready",    32'(m_ir), 32'd1);
        send(32'h0F0F, 32'h00F1, 1'b1);
        wait_result("post_rst", 0);

        // 6. Random regression on each width, with random output stalls
        for (int s = 0; s < 3; s++) begin
            sel = s;
            @(posedge clk); #1;
            for (int i = 0; i < 1000; i++) begin
                send($urandom, $urandom, 1'($urandom_range(0, 1)));
                wait_valid();
                held.res = m_res; held.co = m_co; held.of = m_of;
                pop_cmp($sformatf("rand_n%0d", nib_of_sel(s)));
                if ((i % 50) == 0) begin
                    repeat (3) begin @(posedge clk); #1; end
                    chk("rand_stall_hold", {m_res[30:0], m_co ^ m_of},
                        {held.res[30:0], held.co ^ held.of});
                    handshake(0);
                end else begin
                    handshake($urandom_range(0, 2));
                end
            end
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
